// File: rtl/addsub_div_seq_pkg.sv
// Shared types and helpers for the sequential add/sub divider.
// State encoding, default width and counter width helper.
package addsub_div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DEF_W = 4;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/addsub_div_seq_addsub.sv
// Ripple-carry adder/subtractor shared by the divider datapath.
// sub=1 inverts b and injects a carry-in of one.
module addsub_unit #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0]   c;
   logic [N-1:0] bx;

   always_comb begin
      s    = '0;
      c    = '0;
      bx   = b ^ {N{sub}};
      c[0] = sub;
      for (int i = 0; i < N; i++) begin
         s[i]   = a[i] ^ bx[i] ^ c[i];
         c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
      cout = c[N];
   end

endmodule

// File: rtl/addsub_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Trial subtraction runs on a single shared add/sub unit.
module addsub_div_seq
   import addsub_div_seq_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = cnt_width(W);

   state_t        st, st_n;
   logic [W:0]    r, r_n;
   logic [W-1:0]  q, q_n;
   logic [W-1:0]  dreg, d_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          dz, dz_n;

   logic [W:0]    rs;
   logic [W:0]    t;
   logic          cout;

   assign rs = {r[W-1:0], q[W-1]};

   addsub_unit #(.N(W + 1)) u_addsub (
      .a    (rs),
      .b    ({1'b0, dreg}),
      .sub  (1'b1),
      .s    (t),
      .cout (cout)
   );

   always_comb begin
      st_n  = st;
      r_n   = r;
      q_n   = q;
      d_n   = dreg;
      cnt_n = cnt;
      dz_n  = dz;
      unique case (st)
         IDLE: begin
            if (in_valid) begin
               if (divisor != '0) begin
                  r_n   = '0;
                  q_n   = dividend;
                  d_n   = divisor;
                  cnt_n = '0;
                  st_n  = RUN;
               end else begin
                  r_n   = {1'b0, dividend};
                  q_n   = '1;
                  dz_n  = 1'b1;
                  st_n  = DONE;
               end
            end
         end
         RUN: begin
            // no borrow means the trial subtraction fits
            r_n   = cout ? t : rs;
            q_n   = {q[W-2:0], cout};
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(W - 1)) st_n = DONE;
         end
         DONE: begin
            if (out_ready) begin
               st_n = IDLE;
               dz_n = 1'b0;
            end
         end
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         r    <= '0;
         q    <= '0;
         dreg <= '0;
         cnt  <= '0;
         dz   <= 1'b0;
      end else begin
         st   <= st_n;
         r    <= r_n;
         q    <= q_n;
         dreg <= d_n;
         cnt  <= cnt_n;
         dz   <= dz_n;
      end
   end

   // remainder stays below the divisor, so the guard bit never sets
   a_rmsb: assert property (@(posedge clk) disable iff (!rst_n) r[W] == 1'b0);

   assign in_ready    = (st == IDLE);
   assign out_valid   = (st == DONE);
   assign quotient    = q;
   assign remainder   = r[W-1:0];
   assign div_by_zero = dz;

endmodule

// File: tb/tb_addsub_div_seq.sv
// Bench for addsub_div_seq: directed vectors, corner sequences
// and an all-pairs sweep against a plain-arithmetic model.
module tb_addsub_div_seq;
   import addsub_div_seq_pkg::*;

   localparam int W   = 4;
   localparam int TMO = 50;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      int n;
      int d;
      int q;
      int r;
      int dz;
      int lat;
   } vec_t;

   vec_t tbl[6];

   addsub_div_seq #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_tot++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", nm, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ref_div(input int n, input int d,
                          output int q, output int r, output int dz);
      if (d == 0) begin
         q  = (1 << W) - 1;
         r  = n;
         dz = 1;
      end else begin
         q  = n / d;
         r  = n % d;
         dz = 0;
      end
   endtask

   task automatic offer(input int n, input int d, output time t_acc);
      int k;
      k = 0;
      while (!in_ready && k < TMO) begin
         tick();
         k++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      dividend = n[W-1:0];
      divisor  = d[W-1:0];
      in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic wait_out(output int cyc, output int busy);
      cyc  = 0;
      busy = 0;
      while (!out_valid && cyc < TMO) begin
         if (in_ready) busy++;
         tick();
         cyc++;
      end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int   cyc, busy, bad, q0, r0, eq, er, edz, dly;
      int   n, d;
      bit   prev_fast;
      time  t, prev_t;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dz", int'(div_by_zero), 0);
      #20;
      rst_n = 1'b1;
      tick();

      tbl[0] = '{n: 13, d: 4, q: 3,  r: 1, dz: 0, lat: W};
      tbl[1] = '{n: 15, d: 1, q: 15, r: 0, dz: 0, lat: W};
      tbl[2] = '{n: 3,  d: 9, q: 0,  r: 3, dz: 0, lat: W};
      tbl[3] = '{n: 0,  d: 5, q: 0,  r: 0, dz: 0, lat: W};
      tbl[4] = '{n: 7,  d: 0, q: 15, r: 7, dz: 1, lat: 0};
      tbl[5] = '{n: 9,  d: 3, q: 3,  r: 0, dz: 0, lat: W};

      for (int i = 0; i < 6; i++) begin
         offer(tbl[i].n, tbl[i].d, t);
         wait_out(cyc, busy);
         chk($sformatf("v%0d_latency", i), cyc, tbl[i].lat);
         chk($sformatf("v%0d_busy_ready", i), busy, 0);
         chk($sformatf("v%0d_done_ready", i), int'(in_ready), 0);
         chk($sformatf("v%0d_quotient", i), int'(quotient), tbl[i].q);
         chk($sformatf("v%0d_remainder", i), int'(remainder), tbl[i].r);
         chk($sformatf("v%0d_dz", i), int'(div_by_zero), tbl[i].dz);
         take_result();
         chk($sformatf("v%0d_back_idle", i), int'(in_ready), 1);
      end

      offer(11, 2, t);
      wait_out(cyc, busy);
      q0  = int'(quotient);
      r0  = int'(remainder);
      bad = 0;
      repeat (10) begin
         tick();
         if (int'(quotient) != q0 || int'(remainder) != r0 ||
             !out_valid || in_ready || div_by_zero)
            bad++;
      end
      ref_div(11, 2, eq, er, edz);
      chk("bp_stable", bad, 0);
      chk("bp_result", q0 * 16 + r0, eq * 16 + er);
      take_result();
      chk("bp_idle_ready", int'(in_ready), 1);
      chk("bp_idle_valid", int'(out_valid), 0);

      offer(14, 3, t);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_in_ready", int'(in_ready), 1);
      chk("mr_out_valid", int'(out_valid), 0);
      chk("mr_quotient", int'(quotient), 0);
      chk("mr_remainder", int'(remainder), 0);
      chk("mr_dz", int'(div_by_zero), 0);
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      chk("mr_no_result", int'(out_valid), 0);
      offer(14, 3, t);
      wait_out(cyc, busy);
      chk("mr_quotient2", int'(quotient), 4);
      chk("mr_remainder2", int'(remainder), 2);
      take_result();

      prev_fast = 1'b0;
      prev_t    = 0;
      for (int i = 0; i < 256; i++) begin
         n = i >> 4;
         d = i & 15;
         offer(n, d, t);
         if (prev_fast)
            chk($sformatf("thru_%0d_%0d", n, d),
                int'((t - prev_t) / 10), W + 2);
         wait_out(cyc, busy);
         ref_div(n, d, eq, er, edz);
         chk($sformatf("exh_%0d_%0d", n, d),
             int'({div_by_zero, quotient, remainder}),
             (edz << (2 * W)) | (eq << W) | er);
         dly = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 3));
         repeat (dly) tick();
         take_result();
         prev_fast = (dly == 0) && (d != 0);
         prev_t    = t;
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
